// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width, bit-period helper.
// Used by the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
// Ports: clk, rst (async low), restart_i (sync zero), bit_tick_o.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || cnt_q == LAST)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bit_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// Double-buffered 8N1 UART transmitter (THR -> TSR -> tx_data).
// Ports: clk, rst, thr_data/thr_write in; status flags and tx_data out.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] thr_data,
  input  logic       thr_write,
  output logic       thr_empty,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun,
  output logic       tx_data
);

  localparam int IW = $clog2(DATA_BITS);

  tx_state_e         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        thr_q, thr_d;
  logic [7:0]        tsr_q, tsr_d;
  logic              thr_empty_q, thr_empty_d;
  logic              ovr_q, ovr_d;
  logic              done_q, done_d;
  logic              tx_q, tx_d;
  logic              bit_tick;
  logic              wr_ok;
  logic              xfer;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart_i (xfer),
    .bit_tick_o(bit_tick)
  );

  // A full THR moves into TSR when idle or exactly at the
  // last stop-bit cycle, so chained frames have no gap.
  assign wr_ok = thr_write && thr_empty_q;
  assign xfer  = !thr_empty_q &&
                 (state_q == IDLE ||
                  (state_q == STOP && bit_tick));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    thr_d       = wr_ok ? thr_data : thr_q;
    tsr_d       = xfer ? thr_q : tsr_q;
    thr_empty_d = thr_empty_q;
    ovr_d       = ovr_q | (thr_write && !thr_empty_q);
    done_d      = (state_q == STOP) && bit_tick;

    if (wr_ok) thr_empty_d = 1'b0;
    if (xfer)  thr_empty_d = 1'b1;

    unique case (state_q)
      IDLE: if (xfer) state_d = START;
      START: if (bit_tick) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_tick) begin
        if (idx_q == IW'(DATA_BITS - 1))
          state_d = STOP;
        else
          idx_d = idx_q + IW'(1);
      end
      STOP: if (bit_tick)
        state_d = xfer ? START : IDLE;
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx_data
    // comes straight from a flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tsr_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      thr_q       <= '0;
      tsr_q       <= '0;
      thr_empty_q <= 1'b1;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      thr_q       <= thr_d;
      tsr_q       <= tsr_d;
      thr_empty_q <= thr_empty_d;
      ovr_q       <= ovr_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
    end
  end

  assign thr_empty  = thr_empty_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = done_q;
  assign tx_overrun = ovr_q;
  assign tx_data    = tx_q;

endmodule
